ptw_arbiter: RTL and testbench

Shares the single page-table walker (PTW) port between NREQ TLB requesters (default: ITLB on port 0, DTLB on port 1). It accepts one miss request at a time using round-robin priority and forwards it to the PTW. It then holds the PTW until the walk response returns and routes that response only to the requester that issued it. It sits between the TLBs' `io_ptw_*` ports and the PTW.

---
 rtl/ptw_arbiter_pkg.sv | 48 ++++
 rtl/ptw_arbiter_rr_arbiter.sv | 33 +++
 rtl/ptw_arbiter.sv | 118 +++++++++++
 tb/tb_ptw_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptw_arbiter_pkg.sv
// Shared TLB/PTW definitions: request and PTE packing, arbiter state encoding
// and the round-robin pointer step.
package ptw_arbiter_pkg;

    // Walk request as driven by a TLB, LSB first: fetch, store, addr, mxr, pum, prv
    typedef struct packed {
        logic [1:0]  prv;
        logic        pum;
        logic        mxr;
        logic [26:0] addr;
        logic        store;
        logic        fetch;
    } ptw_req_t;

    localparam int REQ_W = $bits(ptw_req_t);

    // Page-table entry returned by the walker
    typedef struct packed {
        logic [15:0] reserved_for_hardware;
        logic [37:0] ppn;
        logic [1:0]  reserved_for_software;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

    localparam int PTE_W       = $bits(pte_t);
    localparam int PTE_PPN_LSB = 10;
    localparam int PTE_PPN_W   = 38;

    // Arbiter states; the numeric values are visible to debug tooling
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } ptw_state_e;

    // Next round-robin start position after granting idx, wrapping at n
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ptw_arbiter_rr_arbiter.sv
// Combinational round-robin selector: the first asserted request at or after
// ptr (wrapping) wins; produces a one-hot grant and the winner's index.
module ptw_arbiter_rr_arbiter
    import ptw_arbiter_pkg::*;
#(
    parameter int  NREQ = 2,
    localparam int OWW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [OWW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [OWW-1:0]  grant_idx,
    output logic            grant_valid
);

    // Scan NREQ positions starting at ptr and keep the first hit
    always_comb begin
        int cand;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = (int'(ptr) + i) % NREQ;
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = OWW'(cand);
            end
        end
    end

endmodule

// File: rtl/ptw_arbiter.sv
// Shares one page-table walker between NREQ TLBs. One walk at a time: a
// round-robin winner is latched, presented to the PTW, and the response is
// routed back only to that winner.
module ptw_arbiter
    import ptw_arbiter_pkg::*;
#(
    parameter int  NREQ = 2,
    localparam int OWW  = $clog2(NREQ)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       io_in_req_valid,
    output logic [NREQ-1:0]       io_in_req_ready,
    input  logic [NREQ*REQ_W-1:0] io_in_req_bits,
    output logic [NREQ-1:0]       io_in_resp_valid,
    output logic [PTE_W-1:0]      io_in_resp_pte,
    output logic                  io_ptw_req_valid,
    input  logic                  io_ptw_req_ready,
    output logic [REQ_W-1:0]      io_ptw_req_bits,
    input  logic                  io_ptw_resp_valid,
    input  logic [PTE_W-1:0]      io_ptw_resp_pte,
    output logic                  io_busy,
    output logic [OWW-1:0]        io_owner,
    output logic                  io_err_spurious
);

    ptw_state_e      state_q, state_d;
    logic [OWW-1:0]  owner_q, owner_d;
    logic [OWW-1:0]  rr_ptr_q, rr_ptr_d;
    ptw_req_t        bits_q, bits_d;
    logic            err_q, err_d;
    logic            ptw_req_valid_q, ptw_req_valid_d;

    logic [NREQ-1:0] grant;
    logic [OWW-1:0]  grant_idx;
    logic            grant_valid;

    ptw_arbiter_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req         (io_in_req_valid),
        .ptr         (rr_ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Next-state, handshakes and response routing for the single outstanding walk
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        rr_ptr_d         = rr_ptr_q;
        bits_d           = bits_q;
        err_d            = err_q;
        ptw_req_valid_d  = ptw_req_valid_q;
        io_in_req_ready  = '0;
        io_in_resp_valid = '0;

        // A response is only legitimate once the PTW has accepted the request
        if (io_ptw_resp_valid && state_q != ST_WAIT) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                io_in_req_ready = grant;
                if (grant_valid) begin
                    bits_d          = ptw_req_t'(io_in_req_bits[int'(grant_idx)*REQ_W +: REQ_W]);
                    owner_d         = grant_idx;
                    rr_ptr_d        = OWW'(rr_next(int'(grant_idx), NREQ));
                    ptw_req_valid_d = 1'b1;
                    state_d         = ST_REQ;
                end
            end
            ST_REQ: begin
                if (io_ptw_req_ready) begin
                    ptw_req_valid_d = 1'b0;
                    state_d         = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (io_ptw_resp_valid) begin
                    io_in_resp_valid[owner_q] = 1'b1;
                    state_d                   = ST_IDLE;
                end
            end
            default: begin
                ptw_req_valid_d = 1'b0;
                state_d         = ST_IDLE;
            end
        endcase
    end

    // Walk state, latched request and sticky error; reset abandons any walk
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            owner_q         <= '0;
            rr_ptr_q        <= '0;
            bits_q          <= '0;
            err_q           <= 1'b0;
            ptw_req_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            rr_ptr_q        <= rr_ptr_d;
            bits_q          <= bits_d;
            err_q           <= err_d;
            ptw_req_valid_q <= ptw_req_valid_d;
        end
    end

    assign io_ptw_req_valid = ptw_req_valid_q;
    assign io_ptw_req_bits  = bits_q;
    assign io_in_resp_pte   = io_ptw_resp_pte;
    assign io_busy          = (state_q != ST_IDLE);
    assign io_owner         = owner_q;
    assign io_err_spurious  = err_q;

endmodule

// File: tb/tb_ptw_arbiter.sv
// Bench for ptw_arbiter: a two-requester instance checked every cycle against
// a walk-level model, plus a three-requester instance for pointer wrap.
module tb_ptw_arbiter;

    logic clock;
    logic reset_n;

    // Two-requester instance
    logic [1:0]  vld2;
    logic [32:0] b2_0, b2_1;
    logic [1:0]  rdy2, rsp2;
    logic [63:0] pte_out2;
    logic        ptw_vld2, preq_rdy2, presp_vld2;
    logic [32:0] ptw_bits2;
    logic [63:0] presp_pte2;
    logic        busy2, err2;
    logic [0:0]  owner2;

    // Three-requester instance
    logic [2:0]  vld3;
    logic [32:0] b3_0, b3_1, b3_2;
    logic [2:0]  rdy3, rsp3;
    logic [63:0] pte_out3;
    logic        ptw_vld3, preq_rdy3, presp_vld3;
    logic [32:0] ptw_bits3;
    logic [63:0] presp_pte3;
    logic        busy3, err3;
    logic [1:0]  owner3;

    int  n_cmp;
    int  n_err;
    bit  check_en;

    ptw_arbiter #(.NREQ(2)) dut2 (
        .clock             (clock),
        .reset_n           (reset_n),
        .io_in_req_valid   (vld2),
        .io_in_req_ready   (rdy2),
        .io_in_req_bits    ({b2_1, b2_0}),
        .io_in_resp_valid  (rsp2),
        .io_in_resp_pte    (pte_out2),
        .io_ptw_req_valid  (ptw_vld2),
        .io_ptw_req_ready  (preq_rdy2),
        .io_ptw_req_bits   (ptw_bits2),
        .io_ptw_resp_valid (presp_vld2),
        .io_ptw_resp_pte   (presp_pte2),
        .io_busy           (busy2),
        .io_owner          (owner2),
        .io_err_spurious   (err2)
    );

    ptw_arbiter #(.NREQ(3)) dut3 (
        .clock             (clock),
        .reset_n           (reset_n),
        .io_in_req_valid   (vld3),
        .io_in_req_ready   (rdy3),
        .io_in_req_bits    ({b3_2, b3_1, b3_0}),
        .io_in_resp_valid  (rsp3),
        .io_in_resp_pte    (pte_out3),
        .io_ptw_req_valid  (ptw_vld3),
        .io_ptw_req_ready  (preq_rdy3),
        .io_ptw_req_bits   (ptw_bits3),
        .io_ptw_resp_valid (presp_vld3),
        .io_ptw_resp_pte   (presp_pte3),
        .io_busy           (busy3),
        .io_owner          (owner3),
        .io_err_spurious   (err3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Walk-level model of the two-requester instance
    int          m_last;
    bit          m_active;
    bit          m_accepted;
    bit          m_spur;
    int          m_owner;
    logic [32:0] m_bits;
    int          m_w;

    // Requester that should win now: first valid one after the last winner
    function automatic int winner(input logic [1:0] v);
        int c;
        for (int k = 1; k <= 2; k++) begin
            c = (m_last + k) % 2;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_last     = 1;
            m_active   = 0;
            m_accepted = 0;
            m_spur     = 0;
            m_owner    = 0;
            m_bits     = '0;
        end else begin
            if (presp_vld2 && !(m_active && m_accepted)) m_spur = 1;
            if (!m_active) begin
                m_w = winner(vld2);
                if (m_w >= 0) begin
                    m_active   = 1;
                    m_accepted = 0;
                    m_owner    = m_w;
                    m_bits     = (m_w == 0) ? b2_0 : b2_1;
                    m_last     = m_w;
                end
            end else if (!m_accepted) begin
                if (preq_rdy2) m_accepted = 1;
            end else if (presp_vld2) begin
                m_active = 0;
            end
        end
    end

    // Every-cycle comparison of the two-requester instance against the model
    always @(negedge clock) begin
        logic [1:0] exp_rdy;
        logic [1:0] exp_rsp;
        int         w;
        if (check_en) begin
            exp_rdy = '0;
            exp_rsp = '0;
            if (!m_active) begin
                w = winner(vld2);
                if (w >= 0) exp_rdy[w] = 1'b1;
            end
            if (m_active && m_accepted && presp_vld2) exp_rsp[m_owner] = 1'b1;
            checkOutput("m_req_ready", 64'(rdy2), 64'(exp_rdy));
            checkOutput("m_ptw_req_valid", 64'(ptw_vld2), 64'(m_active && !m_accepted));
            checkOutput("m_ptw_req_bits", 64'(ptw_bits2), 64'(m_bits));
            checkOutput("m_resp_valid", 64'(rsp2), 64'(exp_rsp));
            checkOutput("m_resp_pte", pte_out2, presp_pte2);
            checkOutput("m_busy", 64'(busy2), 64'(m_active));
            checkOutput("m_owner", 64'(owner2), 64'(m_owner));
            checkOutput("m_err", 64'(err2), 64'(m_spur));
        end
    end

    task automatic applyStimulus(input logic [1:0] vld, input logic [32:0] b0, input logic [32:0] b1,
                                 input logic rdy, input logic rsp, input logic [63:0] pte);
        @(posedge clock);
        #1;
        vld2       = vld;
        b2_0       = b0;
        b2_1       = b1;
        preq_rdy2  = rdy;
        presp_vld2 = rsp;
        presp_pte2 = pte;
    endtask

    task automatic applyStimulus3(input logic [2:0] vld, input logic rdy, input logic rsp, input logic [63:0] pte);
        @(posedge clock);
        #1;
        vld3       = vld;
        preq_rdy3  = rdy;
        presp_vld3 = rsp;
        presp_pte3 = pte;
    endtask

    // One minimum-length walk on the two-requester instance, starting in IDLE
    task automatic walk2(input logic [1:0] vld, input logic [32:0] b0, input logic [32:0] b1,
                         input int exp_grant, input logic [32:0] exp_bits, input logic [63:0] pte);
        applyStimulus(vld, b0, b1, 1'b0, 1'b0, 64'h0);
        @(negedge clock);
        checkOutput("grant_ready", 64'(rdy2), 64'(1) << exp_grant);
        applyStimulus(vld, b0, b1, 1'b1, 1'b0, 64'h0);
        @(negedge clock);
        checkOutput("ptw_req_valid", 64'(ptw_vld2), 64'd1);
        checkOutput("ptw_req_bits", 64'(ptw_bits2), 64'(exp_bits));
        applyStimulus(vld, b0, b1, 1'b0, 1'b1, pte);
        @(negedge clock);
        checkOutput("resp_route", 64'(rsp2), 64'(1) << exp_grant);
        checkOutput("resp_ppn", 64'(pte_out2[47:10]), 64'(pte[47:10]));
    endtask

    // One minimum-length walk on the three-requester instance, all requesters valid
    task automatic walk3(input int exp_grant);
        logic [32:0] exp_bits;
        exp_bits = 33'h100 + 33'(exp_grant);
        applyStimulus3(3'b111, 1'b0, 1'b0, 64'h0);
        @(negedge clock);
        checkOutput("grant3_ready", 64'(rdy3), 64'(1) << exp_grant);
        applyStimulus3(3'b111, 1'b1, 1'b0, 64'h0);
        @(negedge clock);
        checkOutput("ptw3_req_bits", 64'(ptw_bits3), 64'(exp_bits));
        applyStimulus3(3'b111, 1'b0, 1'b1, 64'h55 << 10);
        @(negedge clock);
        checkOutput("resp3_route", 64'(rsp3), 64'(1) << exp_grant);
    endtask

    initial begin
        int g3[6];
        n_cmp      = 0;
        n_err      = 0;
        check_en   = 0;
        reset_n    = 1'b0;
        vld2       = '0;
        b2_0       = '0;
        b2_1       = '0;
        preq_rdy2  = 1'b0;
        presp_vld2 = 1'b0;
        presp_pte2 = '0;
        vld3       = '0;
        b3_0       = 33'h100;
        b3_1       = 33'h101;
        b3_2       = 33'h102;
        preq_rdy3  = 1'b0;
        presp_vld3 = 1'b0;
        presp_pte3 = '0;
        #1 check_en = 1;

        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        checkOutput("reset_busy", 64'(busy2), 64'd0);
        checkOutput("reset_ptw_valid", 64'(ptw_vld2), 64'd0);
        checkOutput("reset_resp_valid", 64'(rsp2), 64'd0);
        checkOutput("reset_err", 64'(err2), 64'd0);
        checkOutput("reset_owner", 64'(owner2), 64'd0);
        checkOutput("reset_ready_idle", 64'(rdy2), 64'd0);

        // Single request from requester 0: addr=1, fetch=1 packs to 33'h5
        $display("[TB] single request");
        walk2(2'b01, 33'h5, 33'h0, 0, 33'h5, 64'h2000 << 10);
        applyStimulus(2'b00, 33'h0, 33'h0, 1'b0, 1'b0, 64'h0);
        @(negedge clock);
        checkOutput("single_busy_after", 64'(busy2), 64'd0);
        checkOutput("single_addr", 64'(ptw_bits2[28:2]), 64'h1);

        // Requester 1 alone, leaving the pointer back at 0
        walk2(2'b10, 33'h0, 33'h1_2345_6788, 1, 33'h1_2345_6788, 64'h0123_4567_89ab_cdef);

        // Contention: both held valid for four walks
        $display("[TB] contention");
        for (int i = 0; i < 4; i++) begin
            walk2(2'b11, 33'h0_0000_1010, 33'h1_0000_2022, i % 2,
                  (i % 2 == 0) ? 33'h0_0000_1010 : 33'h1_0000_2022, 64'(i + 1) << 10);
        end
        applyStimulus(2'b00, 33'h0, 33'h0, 1'b0, 1'b0, 64'h0);

        // PTW backpressure while request bits toggle
        $display("[TB] backpressure");
        applyStimulus(2'b10, 33'h0, 33'h0_0ABC_DEF1, 1'b0, 1'b0, 64'h0);
        @(negedge clock);
        checkOutput("bp_grant", 64'(rdy2), 64'd2);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b11, 33'($urandom), 33'($urandom) ^ 33'(i), 1'b0, 1'b0, 64'h0);
            @(negedge clock);
            checkOutput("bp_ptw_valid", 64'(ptw_vld2), 64'd1);
            checkOutput("bp_ptw_bits", 64'(ptw_bits2), 64'h0_0ABC_DEF1);
            checkOutput("bp_ready", 64'(rdy2), 64'd0);
        end
        applyStimulus(2'b11, 33'h0, 33'h0, 1'b1, 1'b0, 64'h0);
        applyStimulus(2'b11, 33'h0, 33'h0, 1'b0, 1'b1, 64'h7 << 10);
        @(negedge clock);
        checkOutput("bp_resp_route", 64'(rsp2), 64'd2);
        applyStimulus(2'b00, 33'h0, 33'h0, 1'b0, 1'b0, 64'h0);

        // Spurious response in IDLE
        $display("[TB] spurious response");
        applyStimulus(2'b00, 33'h0, 33'h0, 1'b0, 1'b1, 64'hDEAD_BEEF);
        @(negedge clock);
        checkOutput("spur_no_resp", 64'(rsp2), 64'd0);
        applyStimulus(2'b00, 33'h0, 33'h0, 1'b0, 1'b0, 64'h0);
        @(negedge clock);
        checkOutput("spur_err_set", 64'(err2), 64'd1);
        walk2(2'b01, 33'h0_0000_0333, 33'h0, 0, 33'h0_0000_0333, 64'h9 << 10);
        applyStimulus(2'b00, 33'h0, 33'h0, 1'b0, 1'b0, 64'h0);
        @(negedge clock);
        checkOutput("spur_err_sticky", 64'(err2), 64'd1);

        // Reset in WAIT: pointer currently favours requester 1
        $display("[TB] reset mid-walk");
        applyStimulus(2'b01, 33'h0_0000_0444, 33'h0, 1'b0, 1'b0, 64'h0);
        applyStimulus(2'b00, 33'h0, 33'h0, 1'b1, 1'b0, 64'h0);
        applyStimulus(2'b00, 33'h0, 33'h0, 1'b0, 1'b0, 64'h0);
        @(negedge clock);
        checkOutput("rst_busy_before", 64'(busy2), 64'd1);
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("rst_busy_now", 64'(busy2), 64'd0);
        checkOutput("rst_ptw_valid_now", 64'(ptw_vld2), 64'd0);
        checkOutput("rst_err_cleared", 64'(err2), 64'd0);
        @(posedge clock);
        #1;
        reset_n    = 1'b1;
        presp_vld2 = 1'b1;
        presp_pte2 = 64'h1234 << 10;
        @(negedge clock);
        checkOutput("rst_resp_dropped", 64'(rsp2), 64'd0);
        walk2(2'b11, 33'h0_0000_0555, 33'h1_0000_0666, 0, 33'h0_0000_0555, 64'h3 << 10);
        applyStimulus(2'b00, 33'h0, 33'h0, 1'b0, 1'b0, 64'h0);

        // Three requesters: pointer wraps from 2 back to 0
        $display("[TB] three-requester wrap");
        g3 = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < 6; i++) begin
            walk3(g3[i]);
        end
        applyStimulus3(3'b000, 1'b0, 1'b0, 64'h0);
        @(negedge clock);
        checkOutput("wrap_busy_after", 64'(busy3), 64'd0);

        repeat (2) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
